uart_word_bridge: RTL and testbench

- Byte-to-word adapter between the UART PHY (8-bit receive strobe, 8-bit transmit valid/ready) and the controller command interpreter (32-bit word read/write with `uart_response` handshake).
- RX path: assembles four received bytes into one 32-bit command word and buffers whole words in a small FIFO.
- TX path: serializes one 32-bit response word into four bytes.
- Acts as the responder to the interpreter's `uart_read`/`uart_write` requests.

---
 rtl/uart_word_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_uart_word_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_bridge.sv
// Byte-to-word adapter between the UART PHY and the controller command interpreter.
// RX: four bytes (little-endian) are assembled into a word and queued in a small FIFO.
// TX: one 32-bit response word is serialized as four bytes, LSB first.
module uart_word_bridge #(
  parameter int unsigned RX_FIFO_DEPTH       = 4,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  input  logic        tx_byte_ready,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_byte,
  input  logic        uart_read,
  input  logic        uart_write,
  input  logic [31:0] uart_write_data,
  output logic        uart_rx_empty,
  output logic        uart_tx_empty,
  output logic        uart_response,
  output logic [31:0] uart_read_data,
  output logic        rx_overflow,
  output logic        rx_timeout
);

  localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StSend = 1'b1;

  // RX assembly state
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        rx_timeout_q, rx_timeout_d;

  // RX word FIFO
  logic [31:0]     mem_q [RX_FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rx_overflow_q, rx_overflow_d;

  // Read handshake
  logic        read_prev_q;
  logic        pending_q, pending_d;
  logic [31:0] read_data_q, read_data_d;
  logic        rd_owed_q, rd_owed_d;
  logic        resp_q, resp_d;

  // TX serializer
  logic [0:0]  state_q, state_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_byte_q, tx_byte_d;

  logic [31:0] rx_word;
  logic        word_done;
  logic        timeout_hit;
  logic        fifo_empty;
  logic        fifo_full;
  logic        read_req;
  logic        pop;
  logic        push_ok;
  logic        push_drop;
  logic        tx_accept;
  logic        tx_last;
  logic        rd_src;

  assign rx_word     = {rx_byte, asm_q};
  assign word_done   = rx_byte_valid && (byte_cnt_q == 2'd3);
  assign timeout_hit = (BYTE_TIMEOUT_CYCLES != 0) && (byte_cnt_q != 2'd0) && !rx_byte_valid &&
                       (to_cnt_q == BYTE_TIMEOUT_CYCLES - 1);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CntW'(RX_FIFO_DEPTH));
  assign read_req    = pending_q || (uart_read && !read_prev_q);
  // A read owed behind a write response must not be overtaken by a newer read.
  assign pop         = read_req && !fifo_empty && !rd_owed_q;
  assign push_ok     = word_done && (!fifo_full || pop);
  assign push_drop   = word_done && fifo_full && !pop;
  assign tx_accept   = (state_q == StSend) && tx_byte_ready;
  assign tx_last     = tx_accept && (tx_idx_q == 2'd3);
  assign rd_src      = pop || rd_owed_q;

  // RX byte assembly and partial-word timeout
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    to_cnt_d     = to_cnt_q;
    rx_timeout_d = rx_timeout_q;
    if (rx_byte_valid) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    asm_d[7:0]   = rx_byte;
        2'd1:    asm_d[15:8]  = rx_byte;
        2'd2:    asm_d[23:16] = rx_byte;
        default: asm_d        = asm_q;
      endcase
    end else if (timeout_hit) begin
      byte_cnt_d   = 2'd0;
      rx_timeout_d = 1'b1;
    end
    if (rx_byte_valid || (byte_cnt_q == 2'd0) || timeout_hit) begin
      to_cnt_d = '0;
    end else if (BYTE_TIMEOUT_CYCLES != 0) begin
      to_cnt_d = to_cnt_q + 32'd1;
    end
  end

  // FIFO pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rx_overflow_d = rx_overflow_q || push_drop;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Read request tracking and response sequencing (write pulse wins a collision)
  always_comb begin
    pending_d   = read_req && !pop;
    read_data_d = pop ? mem_q[rd_ptr_q] : read_data_q;
    resp_d      = tx_last || rd_src;
    rd_owed_d   = tx_last && rd_src;
  end

  // TX serializer next state
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_idx_d  = tx_idx_q;
    tx_byte_d = tx_byte_q;
    if (state_q == StIdle) begin
      if (uart_write) begin
        state_d   = StSend;
        tx_data_d = uart_write_data;
        tx_idx_d  = 2'd0;
        tx_byte_d = uart_write_data[7:0];
      end
    end else if (tx_accept) begin
      tx_idx_d = tx_idx_q + 2'd1;
      case (tx_idx_q)
        2'd0:    tx_byte_d = tx_data_q[15:8];
        2'd1:    tx_byte_d = tx_data_q[23:16];
        2'd2:    tx_byte_d = tx_data_q[31:24];
        default: state_d   = StIdle;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_word;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q    <= 2'd0;
      asm_q         <= '0;
      to_cnt_q      <= '0;
      rx_timeout_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rx_overflow_q <= 1'b0;
      read_prev_q   <= 1'b0;
      pending_q     <= 1'b0;
      read_data_q   <= '0;
      rd_owed_q     <= 1'b0;
      resp_q        <= 1'b0;
      state_q       <= StIdle;
      tx_data_q     <= '0;
      tx_idx_q      <= 2'd0;
      tx_byte_q     <= 8'd0;
    end else begin
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      to_cnt_q      <= to_cnt_d;
      rx_timeout_q  <= rx_timeout_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rx_overflow_q <= rx_overflow_d;
      read_prev_q   <= uart_read;
      pending_q     <= pending_d;
      read_data_q   <= read_data_d;
      rd_owed_q     <= rd_owed_d;
      resp_q        <= resp_d;
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      tx_idx_q      <= tx_idx_d;
      tx_byte_q     <= tx_byte_d;
    end
  end

  assign tx_byte_valid  = (state_q == StSend);
  assign tx_byte        = tx_byte_q;
  assign uart_rx_empty  = fifo_empty;
  assign uart_tx_empty  = (state_q == StIdle);
  assign uart_response  = resp_q;
  assign uart_read_data = read_data_q;
  assign rx_overflow    = rx_overflow_q;
  assign rx_timeout     = rx_timeout_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: vector table plus directed corner sequences,
// with RX words and TX bytes tracked in scoreboard queues.
module tb_uart_word_bridge;

  logic        clk;
  logic        reset;
  logic        rx_byte_valid;
  logic [7:0]  rx_byte;
  logic        tx_byte_ready;
  logic        tx_byte_valid;
  logic [7:0]  tx_byte;
  logic        uart_read;
  logic        uart_write;
  logic [31:0] uart_write_data;
  logic        uart_rx_empty;
  logic        uart_tx_empty;
  logic        uart_response;
  logic [31:0] uart_read_data;
  logic        rx_overflow;
  logic        rx_timeout;

  uart_word_bridge #(
    .RX_FIFO_DEPTH      (4),
    .BYTE_TIMEOUT_CYCLES(100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_byte_valid  (rx_byte_valid),
    .rx_byte        (rx_byte),
    .tx_byte_ready  (tx_byte_ready),
    .tx_byte_valid  (tx_byte_valid),
    .tx_byte        (tx_byte),
    .uart_read      (uart_read),
    .uart_write     (uart_write),
    .uart_write_data(uart_write_data),
    .uart_rx_empty  (uart_rx_empty),
    .uart_tx_empty  (uart_tx_empty),
    .uart_response  (uart_response),
    .uart_read_data (uart_read_data),
    .rx_overflow    (rx_overflow),
    .rx_timeout     (rx_timeout)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
    logic [31:0] tx_word;
  } vec_t;

  vec_t        vecs [4];
  logic [31:0] rx_q [$];
  logic [7:0]  tx_q [$];
  int          checks = 0;
  int          errors = 0;
  int          resp_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // TX scoreboard and response counter, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset && uart_response) resp_cnt++;
    if (!reset && tx_byte_valid && tx_byte_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got byte %h, expected none", tx_byte);
      end else begin
        chk("tx_byte", {24'h0, tx_byte}, {24'h0, tx_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    tick();
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
  endtask

  task automatic wait_resp(input string name, input int bound);
    int n;
    n = 0;
    while (!uart_response && n < bound) begin
      tick();
      n++;
    end
    if (!uart_response) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response, expected one within %0d cycles", name, bound);
    end
  endtask

  // Rising read, wait for the response, compare against the RX scoreboard head
  task automatic sb_read(input string name);
    uart_read = 1'b1;
    tick();
    wait_resp(name, 50);
    uart_read = 1'b0;
    if (rx_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %h, expected no word", name, uart_read_data);
    end else begin
      chk(name, uart_read_data, rx_q.pop_front());
    end
    tick();
  endtask

  task automatic do_write(input logic [31:0] w);
    wait_resp_idle();
    uart_write      = 1'b1;
    uart_write_data = w;
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[31:24]);
    tick();
    uart_write = 1'b0;
    tick();
    wait_resp("write_resp", 200);
    tick();
  endtask

  task automatic wait_resp_idle();
    int n;
    n = 0;
    while (!uart_tx_empty && n < 200) begin
      tick();
      n++;
    end
    if (!uart_tx_empty) begin
      checks++;
      errors++;
      $display("FAIL tx_idle_wait: got tx_empty=0, expected 1 within 200 cycles");
    end
  endtask

  initial begin
    int r0;
    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 32'h89ABCDEF};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF, 32'h00000000};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h78563412, 32'hFFFFFFFF};
    vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h01, 32'h01000080, 32'h13572468};

    reset           = 1'b1;
    rx_byte_valid   = 1'b0;
    rx_byte         = 8'h00;
    tx_byte_ready   = 1'b0;
    uart_read       = 1'b0;
    uart_write      = 1'b0;
    uart_write_data = 32'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset values
    chk("rst_tx_valid", {31'h0, tx_byte_valid}, 32'h0);
    chk("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
    chk("rst_response", {31'h0, uart_response}, 32'h0);
    chk("rst_read_data", uart_read_data, 32'h0);
    chk("rst_rx_empty", {31'h0, uart_rx_empty}, 32'h1);
    chk("rst_tx_empty", {31'h0, uart_tx_empty}, 32'h1);
    chk("rst_overflow", {31'h0, rx_overflow}, 32'h0);
    chk("rst_timeout", {31'h0, rx_timeout}, 32'h0);

    // First word, exact read latency, no repeat while uart_read stays high
    send_word(8'h70, 8'h00, 8'h00, 8'h00);
    rx_q.push_back(32'h00000070);
    chk("t1_rx_not_empty", {31'h0, uart_rx_empty}, 32'h0);
    uart_read = 1'b1;
    tick();
    chk("t1_response", {31'h0, uart_response}, 32'h1);
    chk("t1_read_data", uart_read_data, rx_q.pop_front());
    chk("t1_rx_empty", {31'h0, uart_rx_empty}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_repeat", {31'h0, uart_response}, 32'h0);
    end
    uart_read = 1'b0;
    tick();

    // Write timing with tx_byte_ready held high
    tx_byte_ready   = 1'b1;
    uart_write      = 1'b1;
    uart_write_data = 32'h00000001;
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tx_q.push_back(8'h00);
    tick();
    uart_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", {31'h0, tx_byte_valid}, 32'h1);
      chk("t2_byte", {24'h0, tx_byte}, (i == 0) ? 32'h1 : 32'h0);
      chk("t2_no_resp", {31'h0, uart_response}, 32'h0);
      tick();
    end
    chk("t2_response", {31'h0, uart_response}, 32'h1);
    chk("t2_tx_empty", {31'h0, uart_tx_empty}, 32'h1);
    tick();
    chk("t2_resp_once", {31'h0, uart_response}, 32'h0);

    // Table-driven round trips
    for (int i = 0; i < 4; i++) begin
      send_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      rx_q.push_back(vecs[i].exp_word);
      sb_read("vec_read");
      do_write(vecs[i].tx_word);
      chk("vec_tx_drained", tx_q.size(), 32'h0);
    end

    // Overflow at depth 4
    send_word(8'h11, 8'h11, 8'h11, 8'h11);
    send_word(8'h22, 8'h22, 8'h22, 8'h22);
    send_word(8'h33, 8'h33, 8'h33, 8'h33);
    send_word(8'h44, 8'h44, 8'h44, 8'h44);
    chk("ovf_not_yet", {31'h0, rx_overflow}, 32'h0);
    send_word(8'h55, 8'h55, 8'h55, 8'h55);
    chk("ovf_set", {31'h0, rx_overflow}, 32'h1);
    rx_q.push_back(32'h11111111);
    rx_q.push_back(32'h22222222);
    rx_q.push_back(32'h33333333);
    rx_q.push_back(32'h44444444);
    for (int i = 0; i < 4; i++) sb_read("ovf_read");
    chk("ovf_empty", {31'h0, uart_rx_empty}, 32'h1);

    // Partial-word timeout, then a pending read satisfied by the next word
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (90) tick();
    chk("to_not_yet", {31'h0, rx_timeout}, 32'h0);
    repeat (15) tick();
    chk("to_set", {31'h0, rx_timeout}, 32'h1);
    chk("to_no_push", {31'h0, uart_rx_empty}, 32'h1);
    uart_read = 1'b1;
    tick();
    uart_read = 1'b0;
    tick();
    chk("to_pending_wait", {31'h0, uart_response}, 32'h0);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    rx_q.push_back(32'h04030201);
    wait_resp("to_pending_resp", 10);
    chk("to_word", uart_read_data, rx_q.pop_front());
    tick();

    // TX backpressure with an ignored write during SEND
    r0              = resp_cnt;
    tx_byte_ready   = 1'b1;
    uart_write      = 1'b1;
    uart_write_data = 32'hDEADBEEF;
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    tx_q.push_back(8'hAD);
    tx_q.push_back(8'hDE);
    tick();
    uart_write = 1'b0;
    chk("bp_first", {24'h0, tx_byte}, 32'hEF);
    tick();
    tx_byte_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_byte", {24'h0, tx_byte}, 32'hBE);
      chk("bp_hold_valid", {31'h0, tx_byte_valid}, 32'h1);
      uart_write      = (i == 3);
      uart_write_data = 32'h12345678;
      tick();
    end
    uart_write    = 1'b0;
    tx_byte_ready = 1'b1;
    wait_resp_idle();
    repeat (5) tick();
    chk("bp_one_resp", resp_cnt - r0, 32'h1);
    chk("bp_drained", tx_q.size(), 32'h0);
    chk("bp_idle_valid", {31'h0, tx_byte_valid}, 32'h0);

    // Reset in the middle of an RX word and a stalled TX word
    tx_byte_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    uart_write      = 1'b1;
    uart_write_data = 32'hCAFEF00D;
    tick();
    uart_write = 1'b0;
    tick();
    chk("mr_in_send", {31'h0, tx_byte_valid}, 32'h1);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    r0    = resp_cnt;
    chk("mr_tx_valid", {31'h0, tx_byte_valid}, 32'h0);
    chk("mr_tx_empty", {31'h0, uart_tx_empty}, 32'h1);
    chk("mr_rx_empty", {31'h0, uart_rx_empty}, 32'h1);
    chk("mr_overflow", {31'h0, rx_overflow}, 32'h0);
    chk("mr_timeout", {31'h0, rx_timeout}, 32'h0);
    tx_byte_ready = 1'b1;
    repeat (5) tick();
    chk("mr_no_stale_tx", {31'h0, tx_byte_valid}, 32'h0);
    chk("mr_no_resp", resp_cnt - r0, 32'h0);
    send_word(8'h5A, 8'hA5, 8'h3C, 8'hC3);
    rx_q.push_back(32'hC33CA55A);
    sb_read("mr_fresh_word");
    chk("mr_final_tx_valid", {31'h0, tx_byte_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
